// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_core
// Description : Multi-cycle core with control FSM, IMEM/DMEM, 32-entry
//               register file and retired-instruction watchdog.
// Revision    : 1.0
// ============================================================================
module multicycle_core #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int MAX_INSTR  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [33:0]                   imem_wdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  input  logic [4:0]                    probe_reg_addr,
  output logic [DATA_W-1:0]             probe_reg_data,
  input  logic [$clog2(DMEM_DEPTH)-1:0] probe_dm_addr,
  output logic [DATA_W-1:0]             probe_dm_data
);

  localparam int c_IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int c_DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int c_CNT_W   = $clog2(MAX_INSTR + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                r_state;
  logic [c_IMEM_AW-1:0]  r_pc;
  logic [33:0]           r_ir;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_alu_out;
  logic [DATA_W-1:0]     r_mdr;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rf   [32];
  logic [DATA_W-1:0]     r_dmem [DMEM_DEPTH];
  logic [33:0]           r_imem [IMEM_DEPTH];

  logic                  w_reg_write;
  logic                  w_mem_write;
  logic                  w_reg_dst;
  logic                  w_alu_src;
  logic [2:0]            w_alu_ctl;
  logic                  w_mem_to_reg;
  logic [4:0]            w_rs;
  logic [4:0]            w_rt;
  logic [4:0]            w_dest;
  logic [DATA_W-1:0]     w_sign_imm;
  logic [DATA_W-1:0]     w_alu_b;
  logic [DATA_W-1:0]     w_alu_y;
  logic [DATA_W-1:0]     w_wb_data;
  logic [c_DMEM_AW-1:0]  w_dm_idx;

  assign w_reg_write  = r_ir[33];
  assign w_mem_write  = r_ir[32];
  assign w_reg_dst    = r_ir[31];
  assign w_alu_src    = r_ir[30];
  assign w_alu_ctl    = r_ir[29:27];
  assign w_mem_to_reg = r_ir[26];
  assign w_rs         = r_ir[25:21];
  assign w_rt         = r_ir[20:16];
  assign w_dest       = w_reg_dst ? r_ir[15:11] : r_ir[20:16];
  assign w_sign_imm   = DATA_W'($signed(r_ir[15:0]));
  assign w_alu_b      = w_alu_src ? w_sign_imm : r_b;
  assign w_dm_idx     = r_alu_out[c_DMEM_AW-1:0];
  // A store that also sets RegWrite writes back the address, never MDR.
  assign w_wb_data    = (w_mem_to_reg && !w_mem_write) ? r_mdr : r_alu_out;

  always_comb begin
    w_alu_y = '0;
    case (w_alu_ctl)
      3'b000:  w_alu_y = r_a & w_alu_b;
      3'b001:  w_alu_y = r_a | w_alu_b;
      3'b010:  w_alu_y = r_a + w_alu_b;
      3'b110:  w_alu_y = r_a - w_alu_b;
      3'b111:  w_alu_y = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_y = '0;
    endcase
  end

  // IMEM is program storage: loadable only while the core is not executing.
  always_ff @(posedge clk) begin
    if (imem_we && !r_busy) begin
      r_imem[imem_addr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_pc    <= r_pc + c_IMEM_AW'(1);
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a <= r_rf[w_rs];
          r_b <= r_rf[w_rt];
          if (r_ir == 34'd0) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == c_CNT_W'(MAX_INSTR)) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu_out <= w_alu_y;
          if (w_mem_write || w_mem_to_reg) begin
            r_state <= S_MEM;
          end else if (w_reg_write) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + c_CNT_W'(1);
          end
        end
        S_MEM: begin
          if (w_mem_write) begin
            r_dmem[w_dm_idx] <= r_b;
            if (w_reg_write) begin
              r_state <= S_WB;
            end else begin
              r_state <= S_FETCH;
              r_cnt   <= r_cnt + c_CNT_W'(1);
            end
          end else begin
            r_mdr   <= r_dmem[w_dm_idx];
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_reg_write && (w_dest != 5'd0)) begin
            r_rf[w_dest] <= w_wb_data;
          end
          r_cnt   <= r_cnt + c_CNT_W'(1);
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign pc             = r_pc;
  assign probe_reg_data = (probe_reg_addr == 5'd0) ? '0 : r_rf[probe_reg_addr];
  assign probe_dm_data  = r_dmem[probe_dm_addr];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_core
// Description : Directed, table-driven bench for multicycle_core.
// Revision    : 1.0
// ============================================================================
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [33:0] imem_wdata;
  logic [3:0]  pc;
  logic [4:0]  probe_reg_addr;
  logic [31:0] probe_reg_data;
  logic [3:0]  probe_dm_addr;
  logic [31:0] probe_dm_data;

  int checks   = 0;
  int failures = 0;

  logic [33:0] prog [16];

  typedef struct {
    string       name;
    logic [2:0]  alu;
    logic [15:0] ia;
    logic [15:0] ib;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  multicycle_core #(
    .DATA_W(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16), .MAX_INSTR(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .pc(pc),
    .probe_reg_addr(probe_reg_addr), .probe_reg_data(probe_reg_data),
    .probe_dm_addr(probe_dm_addr), .probe_dm_data(probe_dm_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    probe_reg_addr = a;
    #1;
    chk(name, probe_reg_data, exp);
  endtask

  task automatic chk_dm(input string name, input logic [3:0] a, input logic [31:0] exp);
    probe_dm_addr = a;
    #1;
    chk(name, probe_dm_data, exp);
  endtask

  function automatic logic [33:0] itype(input logic rw, input logic mw, input logic m2r,
                                        input logic [2:0] alu, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {rw, mw, 1'b0, 1'b1, alu, m2r, rs, rt, imm};
  endfunction

  function automatic logic [33:0] rtype(input logic [2:0] alu, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {1'b1, 1'b0, 1'b1, 1'b0, alu, 1'b0, rs, rt, rd, 11'd0};
  endfunction

  task automatic wr_imem(input logic [3:0] a, input logic [33:0] d);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = d;
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      wr_imem(4'(i), prog[i]);
    end
  endtask

  // Pulses start and counts rising edges after the start edge until done.
  // With poke set, an IMEM write and a second start are attempted mid-run.
  task automatic run(input bit poke, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 1) begin
        imem_we    = 1'b1;
        imem_addr  = 4'd4;
        imem_wdata = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd9, 16'd1);
        start      = 1'b1;
      end else if (poke && cyc == 2) begin
        imem_we = 1'b0;
        start   = 1'b0;
      end
    end
    chk("run_done", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_test2_prog();
    prog[0] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd1, 16'd5);
    prog[1] = rtype(3'b010, 5'd1, 5'd1, 5'd2);
    prog[2] = itype(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 5'd2, 16'd3);
    prog[3] = itype(1'b1, 1'b0, 1'b1, 3'b010, 5'd0, 5'd3, 16'd3);
    prog[4] = 34'd0;
  endtask

  initial begin
    int cyc;
    int nz;

    tbl[0]  = '{"sub_neg",     3'b110, 16'hFFFD, 16'h0004, 32'hFFFF_FFF9};
    tbl[1]  = '{"slt_true",    3'b111, 16'hFFFD, 16'h0004, 32'h0000_0001};
    tbl[2]  = '{"code_011",    3'b011, 16'hFFFD, 16'h0004, 32'h0000_0000};
    tbl[3]  = '{"and",         3'b000, 16'h00F0, 16'h0FF0, 32'h0000_00F0};
    tbl[4]  = '{"add_wrap",    3'b010, 16'hFFFF, 16'h0001, 32'h0000_0000};
    tbl[5]  = '{"or",          3'b001, 16'h00F0, 16'h0F00, 32'h0000_0FF0};
    tbl[6]  = '{"code_100",    3'b100, 16'h00F0, 16'h0F00, 32'h0000_0000};
    tbl[7]  = '{"add_pos",     3'b010, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE};
    tbl[8]  = '{"slt_false",   3'b111, 16'h0004, 16'hFFFD, 32'h0000_0000};
    tbl[9]  = '{"sub_under",   3'b110, 16'h0000, 16'h0001, 32'hFFFF_FFFF};
    tbl[10] = '{"code_101",    3'b101, 16'h0000, 16'h0001, 32'h0000_0000};

    rst            = 1'b1;
    start          = 1'b0;
    imem_we        = 1'b0;
    imem_addr      = '0;
    imem_wdata     = '0;
    probe_reg_addr = '0;
    probe_dm_addr  = '0;
    #12 rst = 1'b0;

    // Load/store program: results and exact latency
    set_test2_prog();
    load_prog(5);
    run(1'b0, cyc);
    chk("t2_cycles", 32'(cyc), 32'd19);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk_reg("t2_r1", 5'd1, 32'd5);
    chk_reg("t2_r2", 5'd2, 32'd10);
    chk_reg("t2_r3", 5'd3, 32'd10);
    chk_dm("t2_dm3", 4'd3, 32'd10);

    // Mid-cycle asynchronous reset clears state, registers and DMEM
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pc", {28'd0, pc}, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      probe_reg_addr = 5'(i);
      #1;
      if (probe_reg_data != 32'd0) nz++;
    end
    chk("rst_regs_nonzero", 32'(nz), 32'd0);
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      probe_dm_addr = 4'(i);
      #1;
      if (probe_dm_data != 32'd0) nz++;
    end
    chk("rst_dmem_nonzero", 32'(nz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R0 stays zero as a write target and as a source
    prog[0] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd6, 16'd9);
    prog[1] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd0, 16'd7);
    prog[2] = rtype(3'b010, 5'd0, 5'd0, 5'd6);
    prog[3] = 34'd0;
    load_prog(4);
    run(1'b0, cyc);
    chk("r0_cycles", 32'(cyc), 32'd14);
    chk_reg("r0_r6", 5'd6, 32'd0);
    chk_reg("r0_r0", 5'd0, 32'd0);

    // ALU vectors: R1=ia, R2=ib, R7=R1 op R2
    for (int k = 0; k < 11; k++) begin
      prog[0] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd1, tbl[k].ia);
      prog[1] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd2, tbl[k].ib);
      prog[2] = rtype(tbl[k].alu, 5'd1, 5'd2, 5'd7);
      prog[3] = 34'd0;
      load_prog(4);
      run(1'b0, cyc);
      chk({tbl[k].name, "_cycles"}, 32'(cyc), 32'd14);
      chk_reg(tbl[k].name, 5'd7, tbl[k].exp);
    end

    // Watchdog: no HALT anywhere, 20 retirements then forced halt
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      prog[i] = itype(1'b1, 1'b0, 1'b0, 3'b010, 5'd1, 5'd1, 16'd1);
    end
    load_prog(16);
    run(1'b0, cyc);
    chk("wd_cycles", 32'(cyc), 32'd82);
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_pc", {28'd0, pc}, 32'd5);
    chk_reg("wd_r1", 5'd1, 32'd20);

    // Restart from HALT clears err; bare HALT takes two cycles
    wr_imem(4'd0, 34'd0);
    run(1'b0, cyc);
    chk("halt_cycles", 32'(cyc), 32'd2);
    chk("halt_err", {31'd0, err}, 32'd0);
    chk("halt_pc", {28'd0, pc}, 32'd1);

    // Reset during EXEC of the store aborts it
    set_test2_prog();
    load_prog(5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk_dm("abort_dm3", 4'd3, 32'd0);
    chk_reg("abort_r1", 5'd1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, done}, 32'd0);

    // Rerun with an IMEM write and a start attempted while busy
    run(1'b1, cyc);
    chk("rerun_cycles", 32'(cyc), 32'd19);
    chk_reg("rerun_r3", 5'd3, 32'd10);
    chk_reg("rerun_r9", 5'd9, 32'd0);
    chk_dm("rerun_dm3", 4'd3, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
